rv32i_banked_regfile: RTL and testbench

Parametrised successor to the core's BRAM-backed register file. It stores NREGS registers of XLEN bits in a narrow synchronous simple-dual-port BRAM, BRAM_W bits per entry, and moves each register as BEATS = XLEN/BRAM_W sequential beats. It serves a dual-operand read (rs1 and rs2) and a single-register write through req/ready handshakes. Register x0 is hardwired to zero, and an optional clear-on-reset sweep is supported. It sits in decode/execute between the control FSM and the ALU operand registers.

---
 rtl/rv32i_banked_regfile_pkg.sv | 21 ++
 rtl/rv32i_banked_regfile_if.sv | 30 +++
 rtl/rv32i_banked_regfile_bram.sv | 27 ++
 rtl/rv32i_banked_regfile.sv | 201 ++++++++++++++++++++
 tb/tb_rv32i_banked_regfile.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_banked_regfile_pkg.sv
// Shared types and elaboration helpers for the banked register file.
// Registers are stored as BEATS narrow BRAM words.
package rv32i_regfile_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WR      = 3'd2,
    ST_RD      = 3'd3,
    ST_RD_LAST = 3'd4
  } state_e;

  function automatic int beats(input int xlen, input int bram_w);
    return xlen / bram_w;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/rv32i_banked_regfile_if.sv
// Read/write request bus between the control FSM and the banked register file.
interface rv32i_banked_regfile_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            i_rd_req;
  logic [AW-1:0]   i_rs1_addr;
  logic [AW-1:0]   i_rs2_addr;
  logic            o_rd_ready;
  logic [XLEN-1:0] o_rs1_data;
  logic [XLEN-1:0] o_rs2_data;
  logic            o_rd_valid;
  logic            i_wr_req;
  logic [AW-1:0]   i_wr_addr;
  logic [XLEN-1:0] i_wr_data;
  logic            o_wr_ready;
  logic            o_wr_done;

  modport master (
    output i_rd_req, i_rs1_addr, i_rs2_addr, i_wr_req, i_wr_addr, i_wr_data,
    input  o_rd_ready, o_rs1_data, o_rs2_data, o_rd_valid, o_wr_ready, o_wr_done
  );

  modport slave (
    input  i_rd_req, i_rs1_addr, i_rs2_addr, i_wr_req, i_wr_addr, i_wr_data,
    output o_rd_ready, o_rs1_data, o_rs2_data, o_rd_valid, o_wr_ready, o_wr_done
  );
endinterface

// File: rtl/rv32i_banked_regfile_bram.sv
// Simple-dual-port RAM with registered read data; shaped to infer an ICE40 BRAM.
module regfile_sdp_bram #(
  parameter int W     = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          wclk_i,
  input  logic          rclk_i,
  input  logic          wen_i,
  input  logic          ren_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [AW-1:0] raddr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge wclk_i) begin
    if (wen_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge rclk_i) begin
    if (ren_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/rv32i_banked_regfile.sv
// Register file storing each XLEN register as BEATS narrow BRAM words, serving
// one dual-operand read or one write at a time.
// state    | meaning
// CLEAR    | zeroing every BRAM entry after reset
// IDLE     | ready for a read or write request
// WR       | writing one beat per cycle
// RD       | issuing rs1 then rs2 beat addresses
// RD_LAST  | capturing the final returned beat
module rv32i_banked_regfile
  import rv32i_regfile_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BRAM_W         = 16,
  parameter int NREGS          = 32,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input logic i_clk,
  input logic i_rst,
  rv32i_banked_regfile_if.slave bus
);

  localparam int BEATS = beats(XLEN, BRAM_W);
  localparam int AW    = $clog2(NREGS);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BSH   = (BEATS > 1) ? BW : 0;
  localparam int KW    = $clog2(2 * BEATS);
  localparam int DEPTH = NREGS * BEATS;
  localparam int ABW   = $clog2(DEPTH);

  localparam logic [2:0] S_CLEAR   = ST_CLEAR;
  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_WR      = ST_WR;
  localparam logic [2:0] S_RD      = ST_RD;
  localparam logic [2:0] S_RD_LAST = ST_RD_LAST;

  if (((XLEN % BRAM_W) != 0) || !is_pow2(BEATS)) begin : g_bad_beats
    $error("XLEN/BRAM_W must be a power-of-two integer");
  end
  if (!is_pow2(NREGS)) begin : g_bad_nregs
    $error("NREGS must be a power of two");
  end

  logic [2:0]      state_q, state_d;
  logic [KW-1:0]   k_q, k_d, pend_k_q, pend_k_d;
  logic [ABW-1:0]  clr_q, clr_d;
  logic [AW-1:0]   wa_q, wa_d, ra1_q, ra1_d, ra2_q, ra2_d;
  logic [XLEN-1:0] wd_q, wd_d, sh1_q, sh1_d, sh2_q, sh2_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic            pend_q, pend_d, rd_valid_q, rd_valid_d, wr_done_q, wr_done_d;

  logic              bram_wen, bram_ren;
  logic [ABW-1:0]    bram_waddr, bram_raddr;
  logic [BRAM_W-1:0] bram_wdata, bram_rdata;
  logic [BW-1:0]     k_beat, p_beat;
  logic              rdy;

  function automatic logic [ABW-1:0] mkaddr(input logic [AW-1:0] a, input logic [BW-1:0] b);
    return (ABW'(a) << BSH) | ABW'(b);
  endfunction

  assign rdy            = (state_q == S_IDLE) & ~i_rst;
  assign bus.o_wr_ready = rdy;
  // Write has priority, so a read never needs forwarding from an in-flight write.
  assign bus.o_rd_ready = rdy & ~bus.i_wr_req;
  assign bus.o_rs1_data = rs1_q;
  assign bus.o_rs2_data = rs2_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_wr_done  = wr_done_q;

  assign k_beat = (BEATS > 1) ? BW'(k_q) : '0;
  assign p_beat = (BEATS > 1) ? BW'(pend_k_q) : '0;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    clr_d      = clr_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    ra1_d      = ra1_q;
    ra2_d      = ra2_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    pend_d     = 1'b0;
    pend_k_d   = pend_k_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    bram_wen   = 1'b0;
    bram_ren   = 1'b0;
    bram_waddr = '0;
    bram_raddr = '0;
    bram_wdata = '0;

    sh1_d = sh1_q;
    sh2_d = sh2_q;
    if (pend_q) begin
      if (!pend_k_q[KW-1]) sh1_d[p_beat*BRAM_W +: BRAM_W] = bram_rdata;
      else                 sh2_d[p_beat*BRAM_W +: BRAM_W] = bram_rdata;
    end
    if (ra1_q == '0) sh1_d = '0;
    if (ra2_q == '0) sh2_d = '0;

    case (state_q)
      S_CLEAR: begin
        bram_wen   = 1'b1;
        bram_waddr = clr_q;
        clr_d      = clr_q + ABW'(1);
        if (clr_q == ABW'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        k_d = '0;
        if (bus.i_wr_req) begin
          wa_d    = bus.i_wr_addr;
          wd_d    = bus.i_wr_data;
          state_d = S_WR;
        end else if (bus.i_rd_req) begin
          ra1_d   = bus.i_rs1_addr;
          ra2_d   = bus.i_rs2_addr;
          state_d = S_RD;
        end
      end
      S_WR: begin
        bram_wen   = (wa_q != '0);
        bram_waddr = mkaddr(wa_q, k_beat);
        bram_wdata = wd_q[k_beat*BRAM_W +: BRAM_W];
        k_d        = k_q + KW'(1);
        if (k_q == KW'(BEATS - 1)) begin
          state_d   = S_IDLE;
          wr_done_d = 1'b1;
        end
      end
      S_RD: begin
        bram_ren   = 1'b1;
        bram_raddr = mkaddr(k_q[KW-1] ? ra2_q : ra1_q, k_beat);
        pend_d     = 1'b1;
        pend_k_d   = k_q;
        k_d        = k_q + KW'(1);
        if (k_q == KW'(2 * BEATS - 1)) state_d = S_RD_LAST;
      end
      S_RD_LAST: begin
        rs1_d      = sh1_d;
        rs2_d      = sh2_d;
        rd_valid_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (i_rst) bram_wen = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      k_q        <= '0;
      pend_k_q   <= '0;
      clr_q      <= '0;
      wa_q       <= '0;
      wd_q       <= '0;
      ra1_q      <= '0;
      ra2_q      <= '0;
      sh1_q      <= '0;
      sh2_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      pend_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      pend_k_q   <= pend_k_d;
      clr_q      <= clr_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      ra1_q      <= ra1_d;
      ra2_q      <= ra2_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      pend_q     <= pend_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
    end
  end

  regfile_sdp_bram #(
    .W    (BRAM_W),
    .DEPTH(DEPTH),
    .AW   (ABW)
  ) u_bram (
    .wclk_i (i_clk),
    .rclk_i (i_clk),
    .wen_i  (bram_wen),
    .ren_i  (bram_ren),
    .waddr_i(bram_waddr),
    .raddr_i(bram_raddr),
    .wdata_i(bram_wdata),
    .rdata_o(bram_rdata)
  );

endmodule

// File: tb/tb_rv32i_banked_regfile.sv
// Directed bench: dut0 defaults, dut1 with clear-on-reset, dut2 with 8-bit BRAM.
module tb_rv32i_banked_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  int checks = 0;
  int errors = 0;
  int wen_cnt0 = 0;

  logic        wr_req [3];
  logic        rd_req [3];
  logic [4:0]  wr_addr[3];
  logic [4:0]  rs1_a  [3];
  logic [4:0]  rs2_a  [3];
  logic [31:0] wr_data[3];
  logic        wr_rdy [3];
  logic        rd_rdy [3];
  logic        wr_done[3];
  logic        rd_vld [3];
  logic [31:0] rs1_d  [3];
  logic [31:0] rs2_d  [3];

  rv32i_banked_regfile_if #(.XLEN(32), .NREGS(32)) if0 ();
  rv32i_banked_regfile_if #(.XLEN(32), .NREGS(32)) if1 ();
  rv32i_banked_regfile_if #(.XLEN(32), .NREGS(32)) if2 ();

  rv32i_banked_regfile #(.XLEN(32), .BRAM_W(16), .NREGS(32), .CLEAR_ON_RESET(1'b0))
    dut0 (.i_clk(clk), .i_rst(rst0), .bus(if0));
  rv32i_banked_regfile #(.XLEN(32), .BRAM_W(16), .NREGS(32), .CLEAR_ON_RESET(1'b1))
    dut1 (.i_clk(clk), .i_rst(rst1), .bus(if1));
  rv32i_banked_regfile #(.XLEN(32), .BRAM_W(8), .NREGS(32), .CLEAR_ON_RESET(1'b0))
    dut2 (.i_clk(clk), .i_rst(rst2), .bus(if2));

  assign if0.i_wr_req = wr_req[0];  assign if0.i_wr_addr = wr_addr[0];
  assign if0.i_wr_data = wr_data[0]; assign if0.i_rd_req = rd_req[0];
  assign if0.i_rs1_addr = rs1_a[0]; assign if0.i_rs2_addr = rs2_a[0];
  assign wr_rdy[0] = if0.o_wr_ready; assign rd_rdy[0] = if0.o_rd_ready;
  assign wr_done[0] = if0.o_wr_done; assign rd_vld[0] = if0.o_rd_valid;
  assign rs1_d[0] = if0.o_rs1_data;  assign rs2_d[0] = if0.o_rs2_data;

  assign if1.i_wr_req = wr_req[1];  assign if1.i_wr_addr = wr_addr[1];
  assign if1.i_wr_data = wr_data[1]; assign if1.i_rd_req = rd_req[1];
  assign if1.i_rs1_addr = rs1_a[1]; assign if1.i_rs2_addr = rs2_a[1];
  assign wr_rdy[1] = if1.o_wr_ready; assign rd_rdy[1] = if1.o_rd_ready;
  assign wr_done[1] = if1.o_wr_done; assign rd_vld[1] = if1.o_rd_valid;
  assign rs1_d[1] = if1.o_rs1_data;  assign rs2_d[1] = if1.o_rs2_data;

  assign if2.i_wr_req = wr_req[2];  assign if2.i_wr_addr = wr_addr[2];
  assign if2.i_wr_data = wr_data[2]; assign if2.i_rd_req = rd_req[2];
  assign if2.i_rs1_addr = rs1_a[2]; assign if2.i_rs2_addr = rs2_a[2];
  assign wr_rdy[2] = if2.o_wr_ready; assign rd_rdy[2] = if2.o_rd_ready;
  assign wr_done[2] = if2.o_wr_done; assign rd_vld[2] = if2.o_rd_valid;
  assign rs1_d[2] = if2.o_rs1_data;  assign rs2_d[2] = if2.o_rs2_data;

  always @(posedge clk) if (dut0.bram_wen) wen_cnt0 <= wen_cnt0 + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int d, input logic [4:0] a, input logic [31:0] v,
                          input int exp_lat, input string tag);
    int lat;
    @(posedge clk); #1;
    wr_req[d] = 1'b1; wr_addr[d] = a; wr_data[d] = v;
    @(negedge clk);
    chk({tag, "_wr_ready"}, 32'(wr_rdy[d]), 32'd1);
    @(posedge clk); #1;
    wr_req[d] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!wr_done[d] && lat < 40);
    chk({tag, "_wr_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_wr_ready_at_done"}, 32'(wr_rdy[d]), 32'd1);
    @(negedge clk);
    chk({tag, "_wr_done_one_cycle"}, 32'(wr_done[d]), 32'd0);
  endtask

  task automatic do_read(input int d, input logic [4:0] a1, input logic [4:0] a2,
                         input int exp_lat, input logic [31:0] e1, input logic [31:0] e2,
                         input string tag);
    int lat;
    @(posedge clk); #1;
    rd_req[d] = 1'b1; rs1_a[d] = a1; rs2_a[d] = a2;
    @(negedge clk);
    chk({tag, "_rd_ready"}, 32'(rd_rdy[d]), 32'd1);
    @(posedge clk); #1;
    rd_req[d] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rd_vld[d] && lat < 40);
    chk({tag, "_rd_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rs1"}, rs1_d[d], e1);
    chk({tag, "_rs2"}, rs2_d[d], e2);
    chk({tag, "_rd_ready_at_valid"}, 32'(rd_rdy[d]), 32'd1);
    @(negedge clk);
    chk({tag, "_rd_valid_one_cycle"}, 32'(rd_vld[d]), 32'd0);
    chk({tag, "_rs1_held"}, rs1_d[d], e1);
  endtask

  task automatic count_clear(input int d, input int exp_cnt, input string tag);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      if (!wr_rdy[d]) cnt++;
    end while (!wr_rdy[d] && cnt < 300);
    chk(tag, 32'(cnt), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int lat;
    for (int i = 0; i < 3; i++) begin
      wr_req[i] = 1'b0; rd_req[i] = 1'b0; wr_addr[i] = '0;
      rs1_a[i] = '0; rs2_a[i] = '0; wr_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rs1", rs1_d[0], 32'd0);
    chk("rst_rs2", rs2_d[0], 32'd0);
    chk("rst_rd_valid", 32'(rd_vld[0]), 32'd0);
    chk("rst_wr_done", 32'(wr_done[0]), 32'd0);
    chk("rst_ready_low", 32'(wr_rdy[0]), 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("d0_ready_after_reset", 32'(wr_rdy[0]), 32'd1);

    snap = wen_cnt0;
    do_write(0, 5'd5, 32'hDEADBEEF, 3, "x5");
    chk("x5_wen_beats", 32'(wen_cnt0 - snap), 32'd2);
    do_read(0, 5'd5, 5'd0, 6, 32'hDEADBEEF, 32'h0, "rd_5_0");

    // Simultaneous requests: write wins, read accepted on the done cycle.
    @(posedge clk); #1;
    wr_req[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'h12345678;
    rd_req[0] = 1'b1; rs1_a[0] = 5'd7; rs2_a[0] = 5'd7;
    @(negedge clk);
    chk("sim_wr_ready", 32'(wr_rdy[0]), 32'd1);
    chk("sim_rd_ready_low", 32'(rd_rdy[0]), 32'd0);
    @(posedge clk); #1;
    wr_req[0] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!wr_done[0] && lat < 40);
    chk("sim_wr_latency", 32'(lat), 32'd3);
    chk("sim_rd_ready_at_done", 32'(rd_rdy[0]), 32'd1);
    @(posedge clk); #1;
    rd_req[0] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rd_vld[0] && lat < 40);
    chk("sim_rd_latency", 32'(lat), 32'd6);
    chk("sim_rs1", rs1_d[0], 32'h12345678);
    chk("sim_rs2", rs2_d[0], 32'h12345678);

    do_read(0, 5'd7, 5'd5, 6, 32'h12345678, 32'hDEADBEEF, "rd_7_5");

    snap = wen_cnt0;
    do_write(0, 5'd0, 32'hFFFFFFFF, 3, "x0");
    chk("x0_no_wen", 32'(wen_cnt0 - snap), 32'd0);
    do_read(0, 5'd0, 5'd5, 6, 32'h0, 32'hDEADBEEF, "rd_0_5");

    // Reset in the second WR cycle aborts the write without a done pulse.
    @(posedge clk); #1;
    wr_req[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h0BADF00D;
    @(posedge clk); #1;
    wr_req[0] = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b1;
    @(negedge clk);
    chk("abort_done_in_rst", 32'(wr_done[0]), 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b0;
    @(negedge clk);
    chk("abort_no_done", 32'(wr_done[0]), 32'd0);
    chk("abort_ready", 32'(wr_rdy[0]), 32'd1);
    do_write(0, 5'd9, 32'hA5A55A5A, 3, "x9");
    do_read(0, 5'd9, 5'd7, 6, 32'hA5A55A5A, 32'h12345678, "rd_9_7");

    do_write(2, 5'd3, 32'h01020304, 5, "b4_x3");
    do_read(2, 5'd3, 5'd0, 10, 32'h01020304, 32'h0, "b4_rd_3_0");

    @(posedge clk); #1;
    rst1 = 1'b0;
    count_clear(1, 64, "clr_sweep_first");
    do_write(1, 5'd31, 32'hFFFF0000, 3, "clr_x31");
    do_write(1, 5'd1, 32'h00001111, 3, "clr_x1");
    do_read(1, 5'd31, 5'd1, 6, 32'hFFFF0000, 32'h00001111, "clr_pre");
    @(posedge clk); #1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    repeat (20) @(negedge clk);
    chk("clr_ready_mid_sweep", 32'(wr_rdy[1]), 32'd0);
    @(posedge clk); #1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    count_clear(1, 64, "clr_sweep_restart");
    do_read(1, 5'd31, 5'd1, 6, 32'h0, 32'h0, "clr_post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
